// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//
// Contents:
//   XLEN / PC_WIDTH / REG_IDX_WIDTH / STRB_WIDTH   datapath widths
//   FUNCT3_*                                       load/store funct3 encodings
//   SIZE_*                                         access size decoded from funct3[1:0]
//   mem_st_e                                       bus-access FSM state
//   is_misaligned()                                natural-alignment check for an access
//
// The lane logic assumes a 32-bit data bus (four byte lanes).

package mem_stage_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned PC_WIDTH      = 32;
    localparam int unsigned REG_IDX_WIDTH = 5;
    localparam int unsigned STRB_WIDTH    = XLEN / 8;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // funct3[1:0] carries the access size; funct3[2] selects zero-extension.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } mem_st_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational load/store lane alignment.
//
// Ports:
//   funct3_i      access size / signedness
//   addr_lo_i     effective address bits [1:0]
//   sdata_i       store data (rs2)
//   rdata_i       load word from the bus
//   wdata_o       store data replicated onto every lane of its size
//   wstrb_o       byte-write strobes for the access
//   ldata_o       selected byte/half/word, sign- or zero-extended
//   misaligned_o  access is not naturally aligned
//
// Halfword lanes are chosen by addr[1] only and word accesses ignore addr[1:0], so a
// misaligned access that is not trapped upstream still hits a well-defined lane.

module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [XLEN-1:0]       sdata_i,
    input  logic [XLEN-1:0]       rdata_i,
    output logic [XLEN-1:0]       wdata_o,
    output logic [STRB_WIDTH-1:0] wstrb_o,
    output logic [XLEN-1:0]       ldata_o,
    output logic                  misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_en;

    assign byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    assign sign_en  = ~funct3_i[2];

    always_comb begin
        wdata_o = sdata_i;
        wstrb_o = '1;
        ldata_o = rdata_i;
        case (funct3_i[1:0])
            SIZE_B: begin
                wdata_o = {(XLEN / 8){sdata_i[7:0]}};
                wstrb_o = STRB_WIDTH'(1) << addr_lo_i;
                ldata_o = {{(XLEN - 8){byte_sel[7] & sign_en}}, byte_sel};
            end
            SIZE_H: begin
                wdata_o = {(XLEN / 16){sdata_i[15:0]}};
                wstrb_o = STRB_WIDTH'(3) << {addr_lo_i[1], 1'b0};
                ldata_o = {{(XLEN - 16){half_sel[15] & sign_en}}, half_sel};
            end
            default: ;
        endcase
    end

    assign misaligned_o = is_misaligned(funct3_i[1:0], addr_lo_i);

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/gnt/rvalid data bus, aligns load
// data and registers the MEM/WB outputs consumed by writeback. Upstream is stalled while
// a bus access is outstanding.
//
// Parameters:
//   BUS_TIMEOUT  cycles allowed in REQ+WAIT before the access is abandoned (0 = no watchdog)
//
// Configuration macro:
//   MISALIGN_TRAP_EN  when defined, misaligned H/W accesses skip the bus, pulse
//                     mem_misalign_o and retire as a bubble; otherwise low address bits
//                     are ignored and mem_misalign_o is tied 0.
//
// Ports:
//   clk, rst                   clock; synchronous active-high reset
//   ex_mem_*_i                 instruction fields from the EX/MEM register
//   mem_stall_o                hold EX/MEM and earlier stages
//   mem_bus_err_o              1-cycle pulse when the watchdog abandons an access
//   mem_misalign_o             1-cycle pulse on a trapped misaligned access
//   dmem_*                     data-memory bus (req/we/addr/wdata/wstrb out; gnt/rvalid/rdata in)
//   mem_wb_*_o                 MEM/WB register: pc, ALU writeback, load writeback

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_mem_valid_i,
    input  logic [PC_WIDTH-1:0]      ex_mem_pc_i,
    input  logic [REG_IDX_WIDTH-1:0] ex_mem_rd_idx_i,
    input  logic                     ex_mem_rd_en_i,
    input  logic [XLEN-1:0]          ex_mem_alu_res_i,
    input  logic                     ex_mem_load_i,
    input  logic                     ex_mem_store_i,
    input  logic [2:0]               ex_mem_funct3_i,
    input  logic [XLEN-1:0]          ex_mem_sdata_i,
    output logic                     mem_stall_o,
    output logic                     mem_bus_err_o,
    output logic                     mem_misalign_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [XLEN-1:0]          dmem_addr_o,
    output logic [XLEN-1:0]          dmem_wdata_o,
    output logic [STRB_WIDTH-1:0]    dmem_wstrb_o,
    input  logic                     dmem_gnt_i,
    input  logic                     dmem_rvalid_i,
    input  logic [XLEN-1:0]          dmem_rdata_i,
    output logic [PC_WIDTH-1:0]      mem_wb_pc_o,
    output logic                     mem_wb_ex_rd_en_o,
    output logic [REG_IDX_WIDTH-1:0] mem_wb_ex_rd_idx_o,
    output logic [XLEN-1:0]          mem_wb_ex_wdata_o,
    output logic                     mem_wb_mem_rd_en_o,
    output logic [REG_IDX_WIDTH-1:0] mem_wb_mem_rd_idx_o,
    output logic [XLEN-1:0]          mem_wb_mem_wdata_o
);

    localparam int unsigned CntW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    // Abandon in the BUS_TIMEOUT-th cycle spent in REQ+WAIT (counter starts at 0 in REQ).
    localparam logic [CntW-1:0] CntLast = CntW'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);
    localparam logic WdEn = (BUS_TIMEOUT != 0);

    mem_st_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic req_q, req_d;
    logic we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic bus_err_q, bus_err_d;

    logic [PC_WIDTH-1:0] wb_pc_q, wb_pc_d;
    logic wb_ex_en_q, wb_ex_en_d;
    logic [REG_IDX_WIDTH-1:0] wb_ex_idx_q, wb_ex_idx_d;
    logic [XLEN-1:0] wb_ex_wdata_q, wb_ex_wdata_d;
    logic wb_mem_en_q, wb_mem_en_d;
    logic [REG_IDX_WIDTH-1:0] wb_mem_idx_q, wb_mem_idx_d;
    logic [XLEN-1:0] wb_mem_wdata_q, wb_mem_wdata_d;

    logic mem_op;
    logic is_store;
    logic done;
    logic abandon;
    logic trap;
    logic retire;
    logic [XLEN-1:0] al_wdata;
    logic [STRB_WIDTH-1:0] al_wstrb;
    logic [XLEN-1:0] al_ldata;
    logic misaligned;

    mem_lsu_align u_align (
        .funct3_i     (ex_mem_funct3_i),
        .addr_lo_i    (ex_mem_alu_res_i[1:0]),
        .sdata_i      (ex_mem_sdata_i),
        .rdata_i      (dmem_rdata_i),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .ldata_o      (al_ldata),
        .misaligned_o (misaligned)
    );

    assign mem_op   = ex_mem_valid_i & (ex_mem_load_i | ex_mem_store_i);
    // Load wins when both load and store are flagged.
    assign is_store = ex_mem_store_i & ~ex_mem_load_i;
    assign done     = (state_q == StWait) & dmem_rvalid_i;
    // A response arriving in the timeout cycle still completes the access.
    assign abandon  = WdEn & (state_q != StIdle) & (cnt_q == CntLast) & ~done;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    assign trap = mem_op & (state_q == StIdle) & misaligned;

    always_comb begin
        misalign_d = trap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign mem_misalign_o = misalign_q;
`else
    logic unused_misaligned;

    assign trap              = 1'b0;
    assign unused_misaligned = misaligned;
    assign mem_misalign_o    = 1'b0;
`endif

    assign mem_stall_o = mem_op & ~done & ~abandon & ~trap;
    assign retire      = ex_mem_valid_i & ~mem_stall_o & ~abandon & ~trap;

    // Bus-access FSM and request registers.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bus_err_d = abandon;

        unique case (state_q)
            StIdle: begin
                if (mem_op && !trap) begin
                    state_d = StReq;
                    we_d    = is_store;
                    addr_d  = {ex_mem_alu_res_i[XLEN-1:2], 2'b00};
                    wdata_d = al_wdata;
                    wstrb_d = is_store ? al_wstrb : '0;
                end
            end
            StReq: begin
                if (abandon) begin
                    state_d = StIdle;
                end else if (dmem_gnt_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (done || abandon) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Counter spans REQ and WAIT together and restarts on every return to IDLE.
        cnt_d = '0;
        if (WdEn && state_q != StIdle && state_d != StIdle) begin
            cnt_d = cnt_q + 1'b1;
        end

        req_d = (state_d == StReq);
    end

    // MEM/WB register: bubble (all zero) unless an instruction retires this cycle.
    always_comb begin
        wb_pc_d        = '0;
        wb_ex_en_d     = 1'b0;
        wb_ex_idx_d    = '0;
        wb_ex_wdata_d  = '0;
        wb_mem_en_d    = 1'b0;
        wb_mem_idx_d   = '0;
        wb_mem_wdata_d = '0;
        if (retire) begin
            wb_pc_d       = ex_mem_pc_i;
            wb_ex_en_d    = ex_mem_rd_en_i & ~mem_op;
            wb_ex_idx_d   = ex_mem_rd_idx_i;
            wb_ex_wdata_d = ex_mem_alu_res_i;
            if (mem_op && ex_mem_load_i) begin
                wb_mem_en_d    = 1'b1;
                wb_mem_idx_d   = ex_mem_rd_idx_i;
                wb_mem_wdata_d = al_ldata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            bus_err_q      <= 1'b0;
            wb_pc_q        <= '0;
            wb_ex_en_q     <= 1'b0;
            wb_ex_idx_q    <= '0;
            wb_ex_wdata_q  <= '0;
            wb_mem_en_q    <= 1'b0;
            wb_mem_idx_q   <= '0;
            wb_mem_wdata_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
            bus_err_q      <= bus_err_d;
            wb_pc_q        <= wb_pc_d;
            wb_ex_en_q     <= wb_ex_en_d;
            wb_ex_idx_q    <= wb_ex_idx_d;
            wb_ex_wdata_q  <= wb_ex_wdata_d;
            wb_mem_en_q    <= wb_mem_en_d;
            wb_mem_idx_q   <= wb_mem_idx_d;
            wb_mem_wdata_q <= wb_mem_wdata_d;
        end
    end

    assign dmem_req_o          = req_q;
    assign dmem_we_o           = we_q;
    assign dmem_addr_o         = addr_q;
    assign dmem_wdata_o        = wdata_q;
    assign dmem_wstrb_o        = wstrb_q;
    assign mem_bus_err_o       = bus_err_q;
    assign mem_wb_pc_o         = wb_pc_q;
    assign mem_wb_ex_rd_en_o   = wb_ex_en_q;
    assign mem_wb_ex_rd_idx_o  = wb_ex_idx_q;
    assign mem_wb_ex_wdata_o   = wb_ex_wdata_q;
    assign mem_wb_mem_rd_en_o  = wb_mem_en_q;
    assign mem_wb_mem_rd_idx_o = wb_mem_idx_q;
    assign mem_wb_mem_wdata_o  = wb_mem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (BUS_TIMEOUT=255 instance for the main flow, BUS_TIMEOUT=4
// instance for the watchdog) plus a standalone vector table for mem_lsu_align.
// Honours MISALIGN_TRAP_EN in the misaligned-LHU scenario.

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;
    logic valid, wd_valid;
    logic [PC_WIDTH-1:0] pc;
    logic [REG_IDX_WIDTH-1:0] rd_idx;
    logic rd_en, ld, st;
    logic [XLEN-1:0] alu, sdata;
    logic [2:0] funct3;
    logic gnt, rvalid;
    logic [XLEN-1:0] rdata;

    logic stall, bus_err, misalign, req, we;
    logic [XLEN-1:0] addr, wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic [PC_WIDTH-1:0] wb_pc;
    logic wb_ex_en, wb_mem_en;
    logic [REG_IDX_WIDTH-1:0] wb_ex_idx, wb_mem_idx;
    logic [XLEN-1:0] wb_ex_wdata, wb_mem_wdata;

    logic w_stall, w_bus_err, w_req, w_ex_en, w_mem_en;
    logic w_misalign_unused, w_we_unused;
    logic [XLEN-1:0] w_addr_unused, w_wdata_unused;
    logic [STRB_WIDTH-1:0] w_wstrb_unused;
    logic [PC_WIDTH-1:0] w_pc_unused;
    logic [REG_IDX_WIDTH-1:0] w_ex_idx_unused, w_mem_idx_unused;
    logic [XLEN-1:0] w_ex_wdata_unused, w_mem_wdata_unused;

    logic [2:0] a_f3;
    logic [1:0] a_lo;
    logic [XLEN-1:0] a_sdata, a_rdata, a_wdata, a_ldata;
    logic [STRB_WIDTH-1:0] a_wstrb;
    logic a_mis;

    int checks;
    int errors;

    mem_stage #(.BUS_TIMEOUT(255)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_mem_valid_i      (valid),
        .ex_mem_pc_i         (pc),
        .ex_mem_rd_idx_i     (rd_idx),
        .ex_mem_rd_en_i      (rd_en),
        .ex_mem_alu_res_i    (alu),
        .ex_mem_load_i       (ld),
        .ex_mem_store_i      (st),
        .ex_mem_funct3_i     (funct3),
        .ex_mem_sdata_i      (sdata),
        .mem_stall_o         (stall),
        .mem_bus_err_o       (bus_err),
        .mem_misalign_o      (misalign),
        .dmem_req_o          (req),
        .dmem_we_o           (we),
        .dmem_addr_o         (addr),
        .dmem_wdata_o        (wdata),
        .dmem_wstrb_o        (wstrb),
        .dmem_gnt_i          (gnt),
        .dmem_rvalid_i       (rvalid),
        .dmem_rdata_i        (rdata),
        .mem_wb_pc_o         (wb_pc),
        .mem_wb_ex_rd_en_o   (wb_ex_en),
        .mem_wb_ex_rd_idx_o  (wb_ex_idx),
        .mem_wb_ex_wdata_o   (wb_ex_wdata),
        .mem_wb_mem_rd_en_o  (wb_mem_en),
        .mem_wb_mem_rd_idx_o (wb_mem_idx),
        .mem_wb_mem_wdata_o  (wb_mem_wdata)
    );

    mem_stage #(.BUS_TIMEOUT(4)) u_wd (
        .clk                 (clk),
        .rst                 (rst),
        .ex_mem_valid_i      (wd_valid),
        .ex_mem_pc_i         (pc),
        .ex_mem_rd_idx_i     (rd_idx),
        .ex_mem_rd_en_i      (rd_en),
        .ex_mem_alu_res_i    (alu),
        .ex_mem_load_i       (ld),
        .ex_mem_store_i      (st),
        .ex_mem_funct3_i     (funct3),
        .ex_mem_sdata_i      (sdata),
        .mem_stall_o         (w_stall),
        .mem_bus_err_o       (w_bus_err),
        .mem_misalign_o      (w_misalign_unused),
        .dmem_req_o          (w_req),
        .dmem_we_o           (w_we_unused),
        .dmem_addr_o         (w_addr_unused),
        .dmem_wdata_o        (w_wdata_unused),
        .dmem_wstrb_o        (w_wstrb_unused),
        .dmem_gnt_i          (gnt),
        .dmem_rvalid_i       (rvalid),
        .dmem_rdata_i        (rdata),
        .mem_wb_pc_o         (w_pc_unused),
        .mem_wb_ex_rd_en_o   (w_ex_en),
        .mem_wb_ex_rd_idx_o  (w_ex_idx_unused),
        .mem_wb_ex_wdata_o   (w_ex_wdata_unused),
        .mem_wb_mem_rd_en_o  (w_mem_en),
        .mem_wb_mem_rd_idx_o (w_mem_idx_unused),
        .mem_wb_mem_wdata_o  (w_mem_wdata_unused)
    );

    mem_lsu_align u_align (
        .funct3_i     (a_f3),
        .addr_lo_i    (a_lo),
        .sdata_i      (a_sdata),
        .rdata_i      (a_rdata),
        .wdata_o      (a_wdata),
        .wstrb_o      (a_wstrb),
        .ldata_o      (a_ldata),
        .misaligned_o (a_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive point: just after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample point: falling edge.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ex_clear();
        valid    = 1'b0;
        wd_valid = 1'b0;
        pc       = '0;
        rd_idx   = '0;
        rd_en    = 1'b0;
        ld       = 1'b0;
        st       = 1'b0;
        alu      = '0;
        sdata    = '0;
        funct3   = '0;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  lo;
        logic [31:0] rd;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_ldata;
        logic        exp_mis;
    } avec_t;

    avec_t avec [8];

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        ex_clear();
        a_f3 = '0; a_lo = '0; a_sdata = '0; a_rdata = '0;

        // Reset state
        cyc();
        cyc();
        smp();
        check_val("rst_req", 32'(req), 32'd0);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_ex_en", 32'(wb_ex_en), 32'd0);
        check_val("rst_mem_en", 32'(wb_mem_en), 32'd0);
        check_val("rst_pc", wb_pc, 32'd0);
        check_val("rst_bus_err", 32'(bus_err), 32'd0);
        check_val("rst_misalign", 32'(misalign), 32'd0);
        cyc();
        rst = 1'b0;

        // 1: ALU op, one-cycle latency
        valid = 1'b1; pc = 32'h40; rd_idx = 5'd5; rd_en = 1'b1; alu = 32'h1234;
        smp();
        check_val("t1_stall", 32'(stall), 32'd0);
        check_val("t1_req", 32'(req), 32'd0);
        cyc();
        ex_clear();
        smp();
        check_val("t1_ex_en", 32'(wb_ex_en), 32'd1);
        check_val("t1_ex_idx", 32'(wb_ex_idx), 32'd5);
        check_val("t1_ex_wdata", wb_ex_wdata, 32'h1234);
        check_val("t1_pc", wb_pc, 32'h40);
        check_val("t1_mem_en", 32'(wb_mem_en), 32'd0);

        // 2: LB 0x103, immediate gnt and rvalid
        cyc();
        valid = 1'b1; ld = 1'b1; funct3 = FUNCT3_LB; alu = 32'h103; rd_idx = 5'd7; pc = 32'h44;
        smp();
        check_val("t2_stall_c0", 32'(stall), 32'd1);
        check_val("t2_req_c0", 32'(req), 32'd0);
        cyc();
        gnt = 1'b1;
        smp();
        check_val("t2_req_c1", 32'(req), 32'd1);
        check_val("t2_addr", addr, 32'h100);
        check_val("t2_we", 32'(we), 32'd0);
        check_val("t2_stall_c1", 32'(stall), 32'd1);
        cyc();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80FF_FF00;
        smp();
        check_val("t2_stall_c2", 32'(stall), 32'd0);
        check_val("t2_req_c2", 32'(req), 32'd0);
        cyc();
        ex_clear(); rvalid = 1'b0;
        smp();
        check_val("t2_mem_en", 32'(wb_mem_en), 32'd1);
        check_val("t2_mem_idx", 32'(wb_mem_idx), 32'd7);
        check_val("t2_mem_wdata", wb_mem_wdata, 32'hFFFF_FF80);
        check_val("t2_ex_en", 32'(wb_ex_en), 32'd0);
        check_val("t2_pc", wb_pc, 32'h44);

        // 3: SH 0x102, gnt delayed three cycles
        cyc();
        valid = 1'b1; st = 1'b1; funct3 = FUNCT3_SH; alu = 32'h102; sdata = 32'h0000_ABCD;
        pc = 32'h48;
        smp();
        check_val("t3_stall_c0", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            check_val("t3_req_hold", 32'(req), 32'd1);
            check_val("t3_addr", addr, 32'h100);
            check_val("t3_wstrb", 32'(wstrb), 32'hC);
            check_val("t3_wdata", wdata, 32'hABCD_ABCD);
            check_val("t3_we", 32'(we), 32'd1);
            check_val("t3_stall", 32'(stall), 32'd1);
        end
        cyc();
        gnt = 1'b1;
        smp();
        check_val("t3_req_gnt", 32'(req), 32'd1);
        check_val("t3_wstrb_gnt", 32'(wstrb), 32'hC);
        cyc();
        gnt = 1'b0; rvalid = 1'b1;
        smp();
        check_val("t3_stall_done", 32'(stall), 32'd0);
        check_val("t3_req_done", 32'(req), 32'd0);
        cyc();
        ex_clear(); rvalid = 1'b0;
        smp();
        check_val("t3_mem_en", 32'(wb_mem_en), 32'd0);
        check_val("t3_ex_en", 32'(wb_ex_en), 32'd0);

        // 4: LW with no gnt on the BUS_TIMEOUT=4 instance
        cyc();
        wd_valid = 1'b1; ld = 1'b1; funct3 = FUNCT3_LW; alu = 32'h200; rd_idx = 5'd9;
        smp();
        check_val("t4_stall_c0", 32'(w_stall), 32'd1);
        check_val("t4_req_c0", 32'(w_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            smp();
            check_val("t4_req", 32'(w_req), 32'd1);
            check_val("t4_stall", 32'(w_stall), 32'd1);
            check_val("t4_err_early", 32'(w_bus_err), 32'd0);
        end
        cyc();
        smp();
        check_val("t4_req_last", 32'(w_req), 32'd1);
        check_val("t4_stall_drop", 32'(w_stall), 32'd0);
        cyc();
        ex_clear();
        smp();
        check_val("t4_err_pulse", 32'(w_bus_err), 32'd1);
        check_val("t4_req_off", 32'(w_req), 32'd0);
        check_val("t4_mem_en", 32'(w_mem_en), 32'd0);
        check_val("t4_ex_en", 32'(w_ex_en), 32'd0);
        cyc();
        rvalid = 1'b1; rdata = 32'h5555_5555;
        smp();
        check_val("t4_err_once", 32'(w_bus_err), 32'd0);
        cyc();
        rvalid = 1'b0;
        smp();
        check_val("t4_late_rvalid", 32'(w_mem_en), 32'd0);
        check_val("t4_req_idle", 32'(w_req), 32'd0);

        // 5: LHU 0x101
        cyc();
        valid = 1'b1; ld = 1'b1; funct3 = FUNCT3_LHU; alu = 32'h101; rd_idx = 5'd3; pc = 32'h4C;
`ifdef MISALIGN_TRAP_EN
        smp();
        check_val("t5_stall", 32'(stall), 32'd0);
        check_val("t5_req_c0", 32'(req), 32'd0);
        cyc();
        ex_clear();
        smp();
        check_val("t5_misalign", 32'(misalign), 32'd1);
        check_val("t5_req_c1", 32'(req), 32'd0);
        check_val("t5_mem_en", 32'(wb_mem_en), 32'd0);
        check_val("t5_ex_en", 32'(wb_ex_en), 32'd0);
        cyc();
        smp();
        check_val("t5_misalign_off", 32'(misalign), 32'd0);
        check_val("t5_req_c2", 32'(req), 32'd0);
`else
        smp();
        check_val("t5_stall", 32'(stall), 32'd1);
        cyc();
        gnt = 1'b1;
        smp();
        check_val("t5_req", 32'(req), 32'd1);
        check_val("t5_addr", addr, 32'h100);
        cyc();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234_8765;
        smp();
        check_val("t5_stall_done", 32'(stall), 32'd0);
        cyc();
        ex_clear(); rvalid = 1'b0;
        smp();
        check_val("t5_mem_en", 32'(wb_mem_en), 32'd1);
        check_val("t5_mem_wdata", wb_mem_wdata, 32'h0000_8765);
        check_val("t5_misalign", 32'(misalign), 32'd0);
`endif

        // 6: reset while in WAIT, then the held load completes
        cyc();
        valid = 1'b1; ld = 1'b1; funct3 = FUNCT3_LW; alu = 32'h300; rd_idx = 5'd4; pc = 32'h50;
        smp();
        check_val("t6_stall_c0", 32'(stall), 32'd1);
        cyc();
        gnt = 1'b1;
        smp();
        check_val("t6_req_c1", 32'(req), 32'd1);
        cyc();
        gnt = 1'b0;
        smp();
        check_val("t6_wait_req", 32'(req), 32'd0);
        check_val("t6_wait_stall", 32'(stall), 32'd1);
        cyc();
        rst = 1'b1;
        smp();
        cyc();
        rst = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_0000;
        smp();
        check_val("t6_rst_req", 32'(req), 32'd0);
        check_val("t6_rst_mem_en", 32'(wb_mem_en), 32'd0);
        check_val("t6_rst_ex_en", 32'(wb_ex_en), 32'd0);
        check_val("t6_rst_wdata", wb_mem_wdata, 32'd0);
        check_val("t6_rst_err", 32'(bus_err), 32'd0);
        check_val("t6_stray_ignored", 32'(stall), 32'd1);
        cyc();
        rvalid = 1'b0; gnt = 1'b1;
        smp();
        check_val("t6_reissue_req", 32'(req), 32'd1);
        check_val("t6_reissue_stall", 32'(stall), 32'd1);
        cyc();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        smp();
        check_val("t6_stall_done", 32'(stall), 32'd0);
        cyc();
        ex_clear(); rvalid = 1'b0;
        smp();
        check_val("t6_mem_en", 32'(wb_mem_en), 32'd1);
        check_val("t6_mem_idx", 32'(wb_mem_idx), 32'd4);
        check_val("t6_mem_wdata", wb_mem_wdata, 32'hCAFE_F00D);

        // Standalone lane-alignment vectors (sdata fixed at 0x12345678)
        avec[0] = '{FUNCT3_LB,  2'd2, 32'h0080_0000, 32'h7878_7878, 4'b0100, 32'hFFFF_FF80, 1'b0};
        avec[1] = '{FUNCT3_LBU, 2'd1, 32'h0000_F100, 32'h7878_7878, 4'b0010, 32'h0000_00F1, 1'b0};
        avec[2] = '{FUNCT3_LH,  2'd2, 32'h9ABC_0000, 32'h5678_5678, 4'b1100, 32'hFFFF_9ABC, 1'b0};
        avec[3] = '{FUNCT3_LHU, 2'd0, 32'h0000_8001, 32'h5678_5678, 4'b0011, 32'h0000_8001, 1'b0};
        avec[4] = '{FUNCT3_LW,  2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1111, 32'hDEAD_BEEF, 1'b0};
        avec[5] = '{FUNCT3_LH,  2'd0, 32'h0000_7FFF, 32'h5678_5678, 4'b0011, 32'h0000_7FFF, 1'b0};
        avec[6] = '{FUNCT3_LW,  2'd3, 32'h1122_3344, 32'h1234_5678, 4'b1111, 32'h1122_3344, 1'b1};
        avec[7] = '{FUNCT3_LHU, 2'd3, 32'hBEEF_0000, 32'h5678_5678, 4'b1100, 32'h0000_BEEF, 1'b1};
        a_sdata = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            a_f3    = avec[i].f3;
            a_lo    = avec[i].lo;
            a_rdata = avec[i].rd;
            #1;
            check_val($sformatf("al%0d_wdata", i), a_wdata, avec[i].exp_wdata);
            check_val($sformatf("al%0d_wstrb", i), 32'(a_wstrb), 32'(avec[i].exp_wstrb));
            check_val($sformatf("al%0d_ldata", i), a_ldata, avec[i].exp_ldata);
            check_val($sformatf("al%0d_mis", i), 32'(a_mis), 32'(avec[i].exp_mis));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
